// File: rtl/seg_scan_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver.
//
// Contents:
//   SEG_BLANK        all segments off
//   SEG_0 .. SEG_9   segment patterns, bit0 = seg1 (top) ... bit6 = seg7 (middle)
//   ST_BLANK/ST_SHOW legacy-compatible state encodings
//   state_e          scan FSM state type {BLANK, SHOW}
package seg_scan_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [6:0] SEG_0 = 7'b0111111;
   localparam logic [6:0] SEG_1 = 7'b0000110;
   localparam logic [6:0] SEG_2 = 7'b1011011;
   localparam logic [6:0] SEG_3 = 7'b1001111;
   localparam logic [6:0] SEG_4 = 7'b1100110;
   localparam logic [6:0] SEG_5 = 7'b1101101;
   localparam logic [6:0] SEG_6 = 7'b1111100;
   localparam logic [6:0] SEG_7 = 7'b0000111;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1100111;

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_SHOW  = 1'b1;

   typedef enum logic [0:0] {
      BLANK = ST_BLANK,
      SHOW  = ST_SHOW
   } state_e;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Load channel of the 7-segment scan driver: a packed BCD word offered
// over a valid/ready handshake.
//
// Signals:
//   digits_in   packed BCD, digit i = digits_in[4i+3:4i], digit 0 least significant
//   load_valid  digits_in is valid this cycle (producer)
//   load_ready  driver can accept a word (consumer)
// Modports: master = producer of words, slave = the scan driver.
interface seg_scan_driver_if #(
   parameter int NUM_DIGITS = 4
);

   logic [4*NUM_DIGITS-1:0] digits_in;
   logic                    load_valid;
   logic                    load_ready;

   modport master (
      output digits_in,
      output load_valid,
      input  load_ready
   );

   modport slave (
      input  digits_in,
      input  load_valid,
      output load_ready
   );

endinterface

// File: rtl/seg_decode.sv
// BCD digit to 7-segment pattern lookup (purely combinational).
//
// Ports:
//   bcd  in   4-bit digit value
//   seg  out  7-bit segment pattern, bit0 = top ... bit6 = middle, active-high;
//             codes 10..15 decode to all-off
module seg_decode
   import seg_scan_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-segment 7-segment display driver.
//
// Scans one digit at a time: each visit is BLANK_CYCLES of all-off gap
// (anti-ghosting) followed by DWELL_CYCLES with that digit enabled. A
// word accepted over the load channel is held in a pending register and
// only copied to the display register at a frame boundary, so a frame is
// never drawn from two different words.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   load_if     load channel (slave modport): digits_in, load_valid, load_ready
//   segments    segment drive, bit0 = top ... bit6 = middle, active-high
//   digit_en    one-hot-or-zero digit select, active-high
//   frame_done  one-cycle pulse after the last digit's dwell
//   io_oeb      pad output enables, all 0 (every pad is an output)
//
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 is always shown).
module seg_scan_driver
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL_CYCLES = 100,
   parameter int BLANK_CYCLES = 4,
   parameter int CNT_W        = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   seg_scan_driver_if.slave        load_if,
   output logic [6:0]              segments,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    frame_done,
   output logic [6+NUM_DIGITS:0]   io_oeb
);

   localparam int                IDX_W      = $clog2(NUM_DIGITS);
   localparam int                WORD_W     = 4 * NUM_DIGITS;
   localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   // True when digit idx is a leading zero: idx > 0 and it and every more
   // significant digit are zero.
   function automatic logic lead_zero(input logic [WORD_W-1:0] word,
                                      input logic [IDX_W-1:0]  idx);
      logic upper_nz;
      upper_nz = 1'b0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if ((IDX_W'(j) >= idx) && (word[4*j +: 4] != 4'h0))
            upper_nz = 1'b1;
      end
      return (idx != '0) && !upper_nz;
   endfunction

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                frame_end;

   logic [WORD_W-1:0]   disp_q;
   logic [WORD_W-1:0]   pend_q;
   logic                pend_vld_q;
   logic                xfer;

   logic [3:0]          cur_digit;
   logic [6:0]          cur_seg;
   logic                lz_blank;

   logic [6:0]             segments_p1;
   logic [NUM_DIGITS-1:0]  digit_en_p1;
   logic                   frame_done_p1;

   assign load_if.load_ready = ~pend_vld_q;
   assign xfer               = load_if.load_valid & ~pend_vld_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      idx_d     = idx_q;
      frame_end = 1'b0;
      case (state_q)
         BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = SHOW;
               cnt_d   = '0;
            end
         end
         SHOW: begin
            if (cnt_q == DWELL_LAST) begin
               state_d   = BLANK;
               cnt_d     = '0;
               idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
               frame_end = (idx_q == IDX_LAST);
            end
         end
         default: begin
            state_d = BLANK;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= BLANK;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   // A word arriving exactly on the boundary with nothing pending skips
   // the pending register and goes straight to the display.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         disp_q     <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
      end else if (frame_end) begin
         if (pend_vld_q) begin
            disp_q     <= pend_q;
            pend_vld_q <= 1'b0;
         end else if (xfer) begin
            disp_q <= load_if.digits_in;
         end
      end else if (xfer) begin
         pend_q     <= load_if.digits_in;
         pend_vld_q <= 1'b1;
      end
   end

   // idx only advances on entry to BLANK and disp only changes at the
   // frame boundary, so the current idx/disp already describe the next
   // SHOW cycle.
   always_comb begin
      cur_digit = 4'h0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (idx_q == IDX_W'(j))
            cur_digit = disp_q[4*j +: 4];
      end
   end

   seg_decode u_decode (
      .bcd (cur_digit),
      .seg (cur_seg)
   );

`ifdef LEADING_ZERO_BLANK_EN
   assign lz_blank = lead_zero(disp_q, idx_q);
`else
   assign lz_blank = 1'b0;
`endif

   // ---- stage p1: registered pad drive, computed from the next state so
   //      the outputs match the state held during the same cycle ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         segments_p1   <= SEG_BLANK;
         digit_en_p1   <= '0;
         frame_done_p1 <= 1'b0;
      end else begin
         segments_p1   <= (state_d == SHOW && !lz_blank) ? cur_seg : SEG_BLANK;
         digit_en_p1   <= (state_d == SHOW) ? (NUM_DIGITS'(1) << idx_q) : '0;
         frame_done_p1 <= frame_end;
      end
   end

   assign segments   = segments_p1;
   assign digit_en   = digit_en_p1;
   assign frame_done = frame_done_p1;
   assign io_oeb     = '0;

endmodule
